// File: rtl/m_axis_rc_adapt_gen_if.sv
// ---------------------------------------------------------------------------
// m_axis_rc_adapt_gen_if
// AXI-Stream bundle used on both sides of the RC adapter.
//   tdata  [DATA_WIDTH-1:0]   beat payload
//   tkeep  [KEEP_WIDTH-1:0]   byte keep (unused on the core-facing side)
//   tuser  [TUSER_WIDTH-1:0]  sideband (byte enables / discontinue / poison)
//   tlast                     last beat of a packet
//   tvalid                    beat valid
//   tready [3:0]              sink ready; the sink drives all four bits
// Modports: master drives the payload, slave drives tready.
// ---------------------------------------------------------------------------
interface m_axis_rc_adapt_gen_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int TUSER_WIDTH = 85
);
    logic [DATA_WIDTH-1:0]  tdata;
    logic [KEEP_WIDTH-1:0]  tkeep;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;
    logic                   tvalid;
    logic [3:0]             tready;

    modport master (output tdata, tkeep, tuser, tlast, tvalid, input  tready);
    modport slave  (input  tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/m_axis_rc_adapt_gen.sv
// ---------------------------------------------------------------------------
// m_axis_rc_adapt_gen
// Converts UltraScale RC AXIS completions (12-byte descriptor) into LitePCIe
// 3DW completion-TLP beats. A two-entry registered skid stage (output reg +
// skid reg) gives full throughput with one cycle of latency. Poison is
// carried across the packet, the beat count is checked against the length
// fields, and packet / discontinue counters are kept.
// Ports:
//   user_clk, user_reset_n  clock, asynchronous active-low reset
//   rc_a     (slave)        core RC stream in; tuser[KEEP_WIDTH-1:0] = byte
//                           enables, tuser[DISCONTINUE_BIT] = discontinue;
//                           tready driven as four identical bits
//   rc       (master)       LitePCIe stream out; tuser[1]=poison,
//                           tuser[0]=discontinue; only tready[0] is used
//   len_err                 sticky: a packet ended on the wrong beat
//   pkt_cnt                 accepted completions (wrapping)
//   disc_cnt                packets that carried discontinue (wrapping)
// ---------------------------------------------------------------------------
module m_axis_rc_adapt_gen #(
    parameter int DATA_WIDTH      = 256,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int TUSER_WIDTH     = 85,
    parameter int DISCONTINUE_BIT = 42,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                    user_clk,
    input  logic                    user_reset_n,
    m_axis_rc_adapt_gen_if.slave    rc_a,
    m_axis_rc_adapt_gen_if.master   rc,
    output logic                    len_err,
    output logic [CNT_WIDTH-1:0]    pkt_cnt,
    output logic [CNT_WIDTH-1:0]    disc_cnt
);
    localparam int OUT_TUSER_WIDTH = 85;
    localparam int BEAT_DW         = DATA_WIDTH / 32;
    localparam int BEAT_SHIFT      = $clog2(BEAT_DW);

    typedef enum logic {ST_SOP, ST_BODY} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic [1:0]            user;   // {poison, discontinue}
        logic                  last;
    } beat_t;

    state_e                 state_q, state_d;
    beat_t                  out_q, out_d, skid_q, skid_d;
    logic                   out_valid_q, out_valid_d;
    logic                   skid_valid_q, skid_valid_d;
    logic                   tready_a_q;
    logic                   poison_q;
    logic                   disc_seen_q;
    logic [10:0]            beat_cnt_q;
    logic [10:0]            exp_q;
    logic                   len_err_q;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q, disc_cnt_q;

    logic                   in_hs;
    logic                   sop;
    logic                   out_take;
    logic                   disc_bit;
    logic                   disc_seen;
    logic [DATA_WIDTH-1:0]  d_in;
    logic [11:0]            byte_cnt;
    logic [9:0]             dw_len;
    logic [7:0]             fmt_type;
    logic [10:0]            dw_words;
    logic [10:0]            exp_sop;
    logic [10:0]            exp_beats;
    logic [10:0]            beat_num;
    logic                   len_mismatch;
    beat_t                  beat_in;

    assign in_hs    = rc_a.tvalid & tready_a_q;
    assign sop      = (state_q == ST_SOP);
    assign d_in     = rc_a.tdata;
    assign byte_cnt = d_in[27:16];
    assign dw_len   = d_in[41:32];
    assign disc_bit = rc_a.tuser[DISCONTINUE_BIT];

    // ---------------- packet FSM ----------------
    // NOTE: every signal written in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (in_hs) begin
            state_d = rc_a.tlast ? ST_SOP : ST_BODY;
        end
    end

    // ---------------- descriptor remap ----------------
    // Completions with a zero byte count carry no data: fmt 3DW-no-data.
    assign fmt_type = {(byte_cnt != 12'd0) ? 3'b010 : 3'b000,
                       d_in[29] ? 5'h0B : 5'h0A};

    always_comb begin
        beat_in.data = d_in;
        beat_in.keep = rc_a.tuser[KEEP_WIDTH-1:0];
        beat_in.user = {sop ? d_in[46] : poison_q, disc_bit};
        beat_in.last = rc_a.tlast;
        if (sop) begin
            // DW2..DW3: {upper descriptor word, req_id, tag, 0, lower address}
            beat_in.data[127:64] = {d_in[127:96], d_in[63:48], d_in[71:64],
                                    1'b0, d_in[6:0]};
            // DW0..DW1: {cplr_id, status, bcm, byte count, fmt/type, 0, tc,
            //            4'b0, td, ep, attr, 2'b0, length}
            beat_in.data[63:0]   = {d_in[87:72], d_in[45:43], 1'b0, byte_cnt,
                                    fmt_type, 1'b0, d_in[91:89], 4'b0000,
                                    1'b0, 1'b0, d_in[93:92], 2'b00, dw_len};
            beat_in.keep[11:0]   = 12'hFFF;
        end
    end

    // ---------------- length check ----------------
    // A zero length field means 1024 DW; the 3 header DWs share the first beat.
    assign dw_words     = (byte_cnt == 12'd0) ? 11'd0 :
                          (dw_len == 10'd0)   ? 11'd1024 : {1'b0, dw_len};
    assign exp_sop      = (dw_words + 11'd3 + 11'(BEAT_DW - 1)) >> BEAT_SHIFT;
    assign exp_beats    = sop ? exp_sop : exp_q;
    assign beat_num     = sop ? 11'd1 : beat_cnt_q + 11'd1;
    assign len_mismatch = in_hs & rc_a.tlast & (beat_num != exp_beats);
    assign disc_seen    = (~sop & disc_seen_q) | disc_bit;

    // ---------------- skid stage ----------------
    // The skid register only fills when the output is stalled; whenever the
    // output can advance, the skid entry (older) moves out first.
    assign out_take = ~out_valid_q | rc.tready[0];

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_take) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = in_hs;
                if (in_hs) begin
                    skid_d = beat_in;
                end
            end else begin
                out_valid_d = in_hs;
                if (in_hs) begin
                    out_d = beat_in;
                end
            end
        end else if (in_hs) begin
            skid_d       = beat_in;
            skid_valid_d = 1'b1;
        end
    end

    // ---------------- state registers ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q      <= ST_SOP;
            // NOTE: the payload registers are reset too, so the output bus
            // reads all-zero while idle after reset rather than X.
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            tready_a_q   <= 1'b0;
            poison_q     <= 1'b0;
            disc_seen_q  <= 1'b0;
            beat_cnt_q   <= '0;
            exp_q        <= '0;
            len_err_q    <= 1'b0;
            pkt_cnt_q    <= '0;
            disc_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            tready_a_q   <= ~skid_valid_d;
            if (in_hs) begin
                beat_cnt_q  <= beat_num;
                disc_seen_q <= rc_a.tlast ? 1'b0 : disc_seen;
                if (sop) begin
                    exp_q    <= exp_sop;
                    poison_q <= d_in[46];
                end
                if (rc_a.tlast) begin
                    pkt_cnt_q <= pkt_cnt_q + 1'b1;
                    if (disc_seen) begin
                        disc_cnt_q <= disc_cnt_q + 1'b1;
                    end
                end
            end
            if (len_mismatch) begin
                len_err_q <= 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    assign rc_a.tready = {4{tready_a_q}};
    assign rc.tdata    = out_q.data;
    assign rc.tkeep    = out_q.keep;
    assign rc.tuser    = {{(OUT_TUSER_WIDTH - 2){1'b0}}, out_q.user};
    assign rc.tlast    = out_q.last;
    assign rc.tvalid   = out_valid_q;
    assign len_err     = len_err_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign disc_cnt    = disc_cnt_q;

endmodule
